// File: rtl/score_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : score_display_driver
// Description : Converts the processor score word to BCD with a sequential
//               double-dabble engine and scans it onto a multiplexed,
//               active-low, common-anode 7-segment display with leading-zero
//               blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module score_display_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [31:0]             score_in,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic                    overflow,
  output logic                    busy
);

  localparam int c_BCD_W = 4 * NUM_DIGITS;
  localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int c_PRE_W = $clog2(SCAN_DIV);

  // Largest displayable value; one extra bit so the compare is unsigned-safe
  localparam logic [32:0]             c_MAX_VAL = 33'(10 ** NUM_DIGITS - 1);
  localparam logic [c_BCD_W-1:0]      c_NINES   = {NUM_DIGITS{4'h9}};
  localparam logic [NUM_DIGITS-1:0]   c_ONE     = NUM_DIGITS'(1);
  localparam logic [c_PRE_W-1:0]      c_PRE_MAX = c_PRE_W'(SCAN_DIV - 1);
  localparam logic [c_IDX_W-1:0]      c_IDX_MAX = c_IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]              c_SEG_OFF = 7'b1111111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               r_state;
  logic [31:0]          r_last_val;
  logic [31:0]          r_shift;
  logic [c_BCD_W-1:0]   r_work;
  logic [4:0]           r_cnt;
  logic                 r_sat;

  logic [c_BCD_W-1:0]   w_adj;
  logic                 w_unused_carry;

  logic [c_PRE_W-1:0]   r_presc;
  logic [c_IDX_W-1:0]   r_idx;
  logic [3:0]           w_digit;
  logic                 w_blank;
  logic                 w_zero_run;

  // Double-dabble correction: every BCD digit of 5 or more gets +3
  generate
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_adj
      assign w_adj[4*i +: 4] = (r_work[4*i +: 4] >= 4'd5) ? (r_work[4*i +: 4] + 4'd3)
                                                          : r_work[4*i +: 4];
    end
  endgenerate

  // The bit shifted out of the top digit is dropped; it is always zero
  // for values below the saturation threshold
  assign w_unused_carry = w_adj[c_BCD_W-1];

  // Converter FSM: capture a changed score, shift 32 steps, commit result
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_last_val <= '0;
      r_shift    <= '0;
      r_work     <= '0;
      r_cnt      <= '0;
      r_sat      <= 1'b0;
      bcd_out    <= '0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (score_in != r_last_val) begin
            r_last_val <= score_in;
            r_shift    <= score_in;
            busy       <= 1'b1;
            if ({1'b0, score_in} > c_MAX_VAL) begin
              r_work  <= c_NINES;
              r_sat   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_work  <= '0;
              r_sat   <= 1'b0;
              r_cnt   <= '0;
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          r_work  <= {w_adj[c_BCD_W-2:0], r_shift[31]};
          r_shift <= {r_shift[30:0], 1'b0};
          r_cnt   <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          bcd_out  <= r_work;
          overflow <= r_sat;
          busy     <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Scan timing: each digit stays selected for SCAN_DIV cycles
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (r_presc == c_PRE_MAX) begin
      r_presc <= '0;
      r_idx   <= (r_idx == c_IDX_MAX) ? '0 : (r_idx + c_IDX_W'(1));
    end else begin
      r_presc <= r_presc + c_PRE_W'(1);
    end
  end

  // Select the current digit and decide blanking, walking from the top
  // digit down so the zero run covers every more-significant digit
  always_comb begin
    w_digit    = 4'd0;
    w_blank    = 1'b0;
    w_zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero_run = w_zero_run && (bcd_out[4*i +: 4] == 4'd0);
      if (r_idx == c_IDX_W'(i)) begin
        w_digit = bcd_out[4*i +: 4];
        w_blank = w_zero_run && (i != 0);
      end
    end
  end

  // Active-low gfedcba pattern for one BCD digit
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = c_SEG_OFF;
    endcase
  endfunction

  // Register the pin drive so the display sees glitch-free outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      an  <= ~c_ONE;
      seg <= 7'b1000000;
    end else begin
      an  <= ~(c_ONE << r_idx);
      seg <= w_blank ? c_SEG_OFF : seg_decode(w_digit);
    end
  end

endmodule
`default_nettype wire

// File: doc/score_display_driver.md
# score_display_driver

Consumes the processor's 32-bit `score_out` word and drives a multiplexed, active-low, common-anode 7-segment display. A sequential double-dabble converter turns each new score into BCD. A scan counter time-multiplexes the digits with leading-zero blanking. The block sits directly downstream of the processor top level, between `score_out` and the board display pins.

## Interface

- `NUM_DIGITS`, default 4: number of displayed decimal digits; saturation value is 10^NUM_DIGITS − 1.
- `SCAN_DIV`, default 50000: clock cycles each digit is lit; must be ≥ 2.
- `clock`  in  1: single system clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `score_in`  in  32: unsigned score, connected to processor `score_out`.
- `seg`  out  7: segment drive, active-low, bit order {g,f,e,d,c,b,a}.
- `an`  out  NUM_DIGITS: digit enables, active-low one-hot; bit 0 is the least-significant digit.
- `bcd_out`  out  4*NUM_DIGITS: committed BCD value; digit 0 is in bits [3:0].
- `overflow`  out  1: high while the committed value is saturated.
- `busy`  out  1: high while the converter is not in IDLE.

## Operation

- The converter FSM has three states: IDLE, SHIFT and DONE. Registers:
  - `last_val` (32 bits), reset value 0.
  - Binary shift register.
  - Working BCD register.
  - Bit counter, 0..31.
  - `sat` flag.
- **IDLE.** If `score_in != last_val`, capture `score_in` into the shift register and into `last_val`.
  - If `score_in > 10^NUM_DIGITS − 1`: load the working BCD with all digits = 9, set `sat` = 1, and go to DONE.
  - Otherwise: clear the working BCD, set `sat` = 0, set the counter to 0, and go to SHIFT.
  - If `score_in == last_val`, stay in IDLE.
- **SHIFT.** Each cycle performs one double-dabble step:
  - Every working-BCD digit ≥ 5 gets +3.
  - Then {BCD, shift} shifts left by 1.
  - The counter increments. After the step with counter = 31, go to DONE.
  - Carries out of the top BCD digit are discarded; they cannot occur for non-saturated inputs.
- **DONE.** Copy the working BCD to `bcd_out`, copy `sat` to `overflow`, and go to IDLE.
- While `busy` is high, `score_in` is not sampled. A change during conversion is picked up on the first IDLE cycle, because `last_val` holds the captured value.
- **Scan.** The prescaler counts 0..SCAN_DIV−1.
  - On wrap, the digit index advances, going from NUM_DIGITS−1 back to 0.
  - `an` and `seg` are registered every cycle from the current index and `bcd_out`.
- **Blanking.** Digit i is blanked (`seg` = 7'b1111111) when i > 0, `bcd_out` digit i = 0, and every more-significant digit = 0. Digit 0 is never blanked.
- **Decode** (`seg`, active-low gfedcba):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000

## Timing

- **Reset values** (all asynchronous):
  - FSM = IDLE, `last_val` = 0.
  - `bcd_out` = 0, `overflow` = 0, `busy` = 0.
  - Prescaler = 0, index = 0.
  - `an` = all ones except bit 0 = 0, `seg` = 7'b1000000.
- **Normal latency.** `score_in` changes before edge k; IDLE captures it at edge k. SHIFT runs on edges k+1..k+32. DONE commits at edge k+33, so `bcd_out` and `overflow` are valid after edge k+33.
- **Saturated latency.** Capture at edge k, commit at edge k+1.
- **`busy`.** High after edge k and low after the commit edge.
- **Display update.** `an`/`seg` reflect a new index or new `bcd_out` one cycle after the change. Each digit is lit for exactly SCAN_DIV cycles.
- **Reset mid-conversion.** The conversion is abandoned and every output returns to its reset value. After release, a non-zero `score_in` is reconverted because `last_val` = 0.
- **Zero input.** `score_in` = 0 after reset matches `last_val`, so no conversion runs; the display shows "0".

## Test plan

- **Reset display:** assert `reset` low, then release with `score_in` = 0.
  - Required: `an` = 1110, `seg` = 1000000, `busy` = 0.
  - `an` does not change for SCAN_DIV cycles.
- **Basic conversion:** `score_in` = 1234.
  - Required: `busy` rises one edge later; `bcd_out` = 16'h1234 exactly 33 edges after capture; `overflow` = 0.
- **Saturation:** `score_in` = 10000.
  - Required: `bcd_out` = 16'h9999 and `overflow` = 1 two edges after the change; `busy` is high for one cycle.
- **Change during conversion:** `score_in` = 56, then 78 while `busy` is high.
  - Required: `bcd_out` = 0056 at its commit.
  - One idle cycle later a second conversion runs and commits 0078.
- **Blanking and scan, SCAN_DIV = 4:** `score_in` = 7.
  - Required: `an` cycles 1110 → 1101 → 1011 → 0111, changing every 4 cycles.
  - `seg` = 1111000 on digit 0 and 1111111 on digits 1–3.
- **Reset mid-conversion:** `score_in` = 4321; assert `reset` low 10 cycles into SHIFT, then release.
  - Required: all outputs return to their reset values immediately.
  - `bcd_out` = 16'h4321 exactly 34 edges after release: one capture edge plus 33.
